// File: rtl/nco_clk_gen_pkg.sv
// Shared types and helpers for the NCO clock generator.
// The FSM state type and the channel-select width function live here.
package nco_clk_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        RUN    = 1'b1
    } state_t;

    // Width of the channel-select field; a single channel still gets one bit.
    function automatic int chan_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nco_clk_gen_if.sv
// Reconfiguration port of the NCO clock generator: valid/ready transfer
// of a new phase increment for one channel.
interface nco_clk_gen_if #(
    parameter int CHAN_W = 2,
    parameter int ACC_W  = 32
) ();

    logic              cfg_valid;
    logic              cfg_ready;
    logic [CHAN_W-1:0] cfg_chan;
    logic [ACC_W-1:0]  cfg_inc;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_inc,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_inc,
        output cfg_ready
    );

endinterface

// File: rtl/nco_channel.sv
// One phase-accumulator channel: registered MSB clock and wrap strobe.
// clr zeroes the phase and both outputs on the same edge.
module nco_channel #(
    parameter int ACC_W = 32
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic [ACC_W-1:0] inc,
    input  logic             clr,
    output logic             outclk,
    output logic             tick
);

    logic [ACC_W-1:0] acc_reg;
    logic             outclk_reg;
    logic             tick_reg;
    logic [ACC_W:0]   sum_next;

    // The extra top bit is the wrap carry; with inc==0 it never sets and the
    // accumulator, and therefore outclk, simply hold.
    assign sum_next = {1'b0, acc_reg} + {1'b0, inc};

    always_ff @(posedge refclk) begin
        if (!rst || clr) begin
            acc_reg    <= '0;
            outclk_reg <= 1'b0;
            tick_reg   <= 1'b0;
        end else begin
            acc_reg    <= sum_next[ACC_W-1:0];
            outclk_reg <= sum_next[ACC_W-1];
            tick_reg   <= sum_next[ACC_W];
        end
    end

    assign outclk = outclk_reg;
    assign tick   = tick_reg;

endmodule

// File: rtl/nco_clk_gen.sv
// Multi-output NCO clock generator: per-channel phase accumulators with a
// settle/lock FSM gating runtime increment reprogramming.
module nco_clk_gen
    import nco_clk_pkg::*;
#(
    parameter int                          NUM_CLOCKS  = 3,
    parameter int                          ACC_W       = 32,
    parameter int                          LOCK_CYCLES = 16,
    parameter logic [NUM_CLOCKS*ACC_W-1:0] INIT_INC    = '0
) (
    input  logic                  refclk,
    input  logic                  rst,
    nco_clk_gen_if.slave          cfg,
    output logic [NUM_CLOCKS-1:0] outclk,
    output logic [NUM_CLOCKS-1:0] tick,
    output logic                  locked
);

    localparam int CHAN_W = chan_w(NUM_CLOCKS);
    localparam int CNT_W  = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    state_t                             state_reg;
    state_t                             state_next;
    logic [CNT_W-1:0]                   cnt_reg;
    logic [CNT_W-1:0]                   cnt_next;
    logic                               xfer;
    logic                               chan_ok;
    logic [NUM_CLOCKS-1:0]              load;
    logic [NUM_CLOCKS-1:0][ACC_W-1:0]   inc_reg;

    assign xfer    = (state_reg == RUN) && cfg.cfg_valid;
    assign chan_ok = (int'(cfg.cfg_chan) < NUM_CLOCKS);

    always_ff @(posedge refclk) begin
        if (!rst) begin
            state_reg <= SETTLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            SETTLE: begin
                // Counter saturates at the last value; it never wraps here.
                if (cnt_reg == CNT_LAST) begin
                    state_next = RUN;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RUN: begin
                // Out-of-range channel: transfer is consumed with no effect.
                if (xfer && chan_ok) begin
                    state_next = SETTLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = SETTLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Both handshake ready and lock indication come straight from the state flop.
    assign cfg.cfg_ready = (state_reg == RUN);
    assign locked        = (state_reg == RUN);

    generate
        for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
            assign load[gi] = xfer && chan_ok && (cfg.cfg_chan == CHAN_W'(gi));

            always_ff @(posedge refclk) begin
                if (!rst) begin
                    inc_reg[gi] <= INIT_INC[gi*ACC_W +: ACC_W];
                end else if (load[gi]) begin
                    inc_reg[gi] <= cfg.cfg_inc;
                end
            end

            nco_channel #(
                .ACC_W (ACC_W)
            ) u_chan (
                .refclk (refclk),
                .rst    (rst),
                .inc    (inc_reg[gi]),
                .clr    (load[gi]),
                .outclk (outclk[gi]),
                .tick   (tick[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_nco_clk_gen.sv
// Scoreboard bench for nco_clk_gen: stimulus queues per-edge expected outputs,
// a negedge monitor pops and compares them.
module tb_nco_clk_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] outclk;
    logic [2:0] tick;
    logic       locked;
    int         edge_cnt = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        int         cyc;
        string      name;
        logic [7:0] exp;   // {locked, cfg_ready, outclk[2:0], tick[2:0]}
    } exp_t;

    exp_t q[$];

    nco_clk_gen_if #(.CHAN_W(2), .ACC_W(8)) cfg_if ();

    nco_clk_gen #(
        .NUM_CLOCKS  (3),
        .ACC_W       (8),
        .LOCK_CYCLES (4),
        .INIT_INC    ({8'd0, 8'd96, 8'd64})
    ) dut (
        .refclk (clk),
        .rst    (rst),
        .cfg    (cfg_if.slave),
        .outclk (outclk),
        .tick   (tick),
        .locked (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Hand-derived patterns: ch0 inc=64 (period 4), ch1 inc=96 (wraps at 3,6,8 of 8).
    function automatic logic c0t64(input int k);
        return (k > 0) && (k % 4 == 0);
    endfunction
    function automatic logic c0o64(input int k);
        return (k % 4 == 2) || (k % 4 == 3);
    endfunction
    function automatic logic c1t(input int k);
        return (k > 0) && ((k % 8 == 3) || (k % 8 == 6) || (k % 8 == 0));
    endfunction
    function automatic logic c1o(input int k);
        return (k % 8 == 2) || (k % 8 == 4) || (k % 8 == 5) || (k % 8 == 7);
    endfunction
    // ch0 after a clear with inc=128: high on odd steps, tick on even steps.
    function automatic logic c0t128(input int j);
        return (j > 0) && (j % 2 == 0);
    endfunction
    function automatic logic c0o128(input int j);
        return (j % 2 == 1);
    endfunction

    function automatic logic [7:0] mk(input logic lk, input logic o1, input logic o0,
                                      input logic t1, input logic t0);
        return {lk, lk, 1'b0, o1, o0, 1'b0, t1, t0};
    endfunction

    task automatic push(input int cyc, input string name, input logic [7:0] exp);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic push_after_reset(input int r, input string name);
        for (int k = 0; k <= 16; k++)
            push(r + k, name, mk(k >= 4, c1o(k), c0o64(k), c1t(k), c0t64(k)));
    endtask

    task automatic goto_edge(input int n);
        while (edge_cnt < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [1:0] ch, input logic [7:0] v);
        int waited;
        @(negedge clk);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = ch;
        cfg_if.cfg_inc   = v;
        waited = 0;
        while (cfg_if.cfg_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (waited >= 40) begin
            errors++;
            $display("FAIL cfg_handshake ch=%0d inc=%0d: cfg_ready got %b, required 1 within 40 cycles",
                     ch, v, cfg_if.cfg_ready);
        end else begin
            $display("cfg ch=%0d inc=%0d accepted at edge %0d", ch, v, edge_cnt + 1);
        end
        @(posedge clk);
        @(negedge clk);
        cfg_if.cfg_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [7:0] act;
        exp_t       e;
        act = {locked, cfg_if.cfg_ready, outclk, tick};
        while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
            e = q.pop_front();
            checks++;
            if (e.cyc < edge_cnt) begin
                errors++;
                $display("FAIL %s edge %0d: not sampled in time (now %0d), required %b",
                         e.name, e.cyc, edge_cnt, e.exp);
            end else if (act !== e.exp) begin
                errors++;
                $display("FAIL %s edge %0d: got %b required %b (lk rdy oc[2:0] tk[2:0])",
                         e.name, e.cyc, act, e.exp);
            end else begin
                $display("ok   %s edge %0d: %b", e.name, e.cyc, act);
            end
        end
    end

    initial begin
        int r, c, d, f, r2;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan  = 2'd0;
        cfg_if.cfg_inc   = 8'd0;

        // Reset, release, lock timing and initial channel patterns.
        repeat (3) @(posedge clk);
        #1;
        r = edge_cnt;
        push_after_reset(r, "reset_run");
        @(negedge clk);
        rst = 1'b1;

        // Reprogram ch0 to 128: ch0 cleared, relock, ch1 unbroken.
        goto_edge(r + 16);
        c = r + 17;
        for (int j = 0; j <= 12; j++)
            push(c + j, "cfg_ch0_128",
                 mk(j >= 4, c1o(c + j - r), c0o128(j), c1t(c + j - r), c0t128(j)));
        send(2'd0, 8'd128);

        // Out-of-range channel: consumed, nothing changes, lock stays.
        goto_edge(c + 12);
        d = c + 13;
        for (int e = d; e <= d + 10; e++)
            push(e, "cfg_bad_chan",
                 mk(1'b1, c1o(e - r), c0o128(e - c), c1t(e - r), c0t128(e - c)));
        send(2'd3, 8'd200);

        // Reprogram again, then reset mid-SETTLE: incs return to INIT_INC.
        goto_edge(d + 10);
        f  = d + 11;
        r2 = f + 2;
        push(f,     "cfg_ch0_32",   mk(1'b0, c1o(f - r),     1'b0, c1t(f - r),     1'b0));
        push(f + 1, "settle_ch0_32", mk(1'b0, c1o(f + 1 - r), 1'b0, c1t(f + 1 - r), 1'b0));
        push_after_reset(r2, "rst_in_settle");
        send(2'd0, 8'd32);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
